// File: rtl/rca_seq_adder.sv
// rca_seq_adder: sequences one K-bit ripple-carry adder over W = K*M bit
// operands, one chunk per cycle from LSB to MSB, with the chunk carry held
// in a register between cycles.
//
// Ports:
//   CLK        clock, rising edge
//   RST        asynchronous active-high reset
//   IN_VALID   operand request
//   IN_READY   operands accepted when high (IDLE only)
//   A, B       W-bit operands, sampled on accept
//   C_IN       carry into chunk 0, sampled on accept
//   OUT_VALID  result available (DONE only)
//   OUT_READY  consumer takes the result
//   SUM        registered result, (A+B+C_IN) mod 2^W
//   C_OUT      final carry out (only when RCA_SEQ_COUT_EN is defined)
//
// Optional feature macro: RCA_SEQ_COUT_EN adds the C_OUT port and register.
module rca_seq_adder #(
    parameter int unsigned K = 4,
    parameter int unsigned M = 4
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           IN_VALID,
    output logic           IN_READY,
    input  logic [K*M-1:0] A,
    input  logic [K*M-1:0] B,
    input  logic           C_IN,
    output logic           OUT_VALID,
    input  logic           OUT_READY,
`ifdef RCA_SEQ_COUT_EN
    output logic [K*M-1:0] SUM,
    output logic           C_OUT
`else
    output logic [K*M-1:0] SUM
`endif
);

    localparam int unsigned W  = K * M;
    localparam int unsigned CW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic            carry_q;
    logic [CW-1:0]   cnt_q;
    logic [K-1:0]    a_chunk;
    logic [K-1:0]    b_chunk;
    logic [K:0]      add_d;
`ifdef RCA_SEQ_COUT_EN
    logic            cout_q;
`endif

    // The single narrow adder: zero-extended chunks plus the registered carry.
    always_comb begin
        a_chunk = a_q[cnt_q*K +: K];
        b_chunk = b_q[cnt_q*K +: K];
        add_d   = {1'b0, a_chunk} + {1'b0, b_chunk} + {{K{1'b0}}, carry_q};
    end

    // Handshake flags decode straight from the state flops.
    assign IN_READY  = (state_q == IDLE);
    assign OUT_VALID = (state_q == DONE);
    assign SUM       = sum_q;
`ifdef RCA_SEQ_COUT_EN
    assign C_OUT     = cout_q;
`endif

    // Controller and datapath registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
`ifdef RCA_SEQ_COUT_EN
            cout_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (IN_VALID) begin
                        a_q     <= A;
                        b_q     <= B;
                        carry_q <= C_IN;
                        cnt_q   <= '0;
                        sum_q   <= '0;
`ifdef RCA_SEQ_COUT_EN
                        cout_q  <= 1'b0;
`endif
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[cnt_q*K +: K] <= add_d[K-1:0];
                    carry_q             <= add_d[K];
                    if (cnt_q == CW'(M - 1)) begin
`ifdef RCA_SEQ_COUT_EN
                        cout_q  <= add_d[K];
`endif
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/rca_seq_adder.md
# rca_seq_adder

Multi-cycle wide adder controller that sequences one narrow ripple-carry adder over a W-bit operand pair, K bits per cycle, from least- to most-significant chunk. The chunk carry is registered between cycles. Operands enter through a valid/ready handshake and the result leaves through another. It sits between the operand source and any consumer that needs W-bit additions but can only afford a K-bit adder's area and critical path.

## Interface
- K, default 4: chunk width in bits, meaning the width of the adder used each cycle (K ≥ 1).
- M, default 4: number of chunks (M ≥ 1); operand width W = K*M.
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- IN_VALID  input  1  operand request.
- IN_READY  output  1  block can accept operands; high only in IDLE.
- A  input  W  operand A, sampled on accept.
- B  input  W  operand B, sampled on accept.
- C_IN  input  1  carry into chunk 0, sampled on accept.
- OUT_VALID  output  1  result available; high only in DONE.
- OUT_READY  input  1  consumer takes the result.
- SUM  output  W  registered result, (A+B+C_IN) mod 2^W.
- C_OUT  output  1  final carry out of the top chunk. Present only with RCA_SEQ_COUT_EN.

## Operation
- Datapath: one adder instance, K+1 bits wide, fed with zero-extended chunk operands and the registered carry.
  - Bits [K-1:0] give the chunk sum.
  - Bit K is the next carry.
- Registers:
  - a_q, b_q (W bits each).
  - carry_q.
  - cnt (ceil(log2 M) bits, minimum 1).
  - SUM.
  - C_OUT.
  - state.
- States:
  - IDLE: IN_READY=1.
    - On IN_VALID&IN_READY: load a_q=A, b_q=B, carry_q=C_IN, cnt=0, SUM=0, C_OUT=0, then go to RUN.
    - Otherwise hold.
  - RUN: each cycle, SUM[cnt*K +: K] = chunk sum of a_q, b_q and carry_q at chunk cnt.
    - carry_q = adder bit K.
    - If cnt==M-1: C_OUT = adder bit K, then go to DONE.
    - Otherwise cnt = cnt+1.
  - DONE: OUT_VALID=1; SUM and C_OUT held stable.
    - On OUT_READY: go to IDLE.
    - Otherwise hold indefinitely.
- IN_VALID outside IDLE is ignored, and A/B/C_IN changes after accept have no effect.
- OUT_READY outside DONE is ignored.
- Arithmetic wraps modulo 2^W. The carry ripples chunk to chunk across cycles, so all-ones + C_IN=1 produces a carry from every chunk.
- M=1: RUN lasts exactly one cycle.

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE, so IN_READY=1.
  - OUT_VALID=0.
  - SUM=0, C_OUT=0.
  - carry_q=0, cnt=0, a_q=b_q=0.
- Reset asserted mid-RUN or in DONE aborts the operation and discards the result. The first accept after reset release behaves normally.
- IN_READY and OUT_VALID decode directly from state flops, with no combinational path from IN_VALID or OUT_READY.
- Latency:
  - Accept at edge t.
  - Chunk i is written at edge t+1+i.
  - OUT_VALID rises after edge t+M.
- Throughput: with OUT_READY held high, DONE lasts 1 cycle and IN_READY returns after edge t+M+1. That is one operation per M+2 cycles. Accept is never overlapped with DONE.
- Critical path: one (K+1)-bit ripple, independent of M.

## Configuration
- RCA_SEQ_COUT_EN defined:
  - C_OUT port and register exist.
  - C_OUT is written at the last RUN cycle and is valid together with OUT_VALID.
- Undefined:
  - No C_OUT port or register.
  - The final carry is discarded.
  - SUM and all timing are identical.

## Test plan
All scenarios use K=4, M=4 (W=16).
- Reset: assert RST mid-run → IN_READY=1, OUT_VALID=0, SUM=0x0000, C_OUT=0 immediately, before any clock edge.
- A=0x00FF, B=0x0001, C_IN=0 → SUM=0x0100, C_OUT=0. OUT_VALID rises exactly 4 edges after the accept edge; IN_READY=0 throughout.
- A=0xFFFF, B=0x0000, C_IN=1 → SUM=0x0000, C_OUT=1 (carry crosses all four chunks). Also A=0x8000, B=0x8000 → SUM=0x0000, C_OUT=1.
- Backpressure: OUT_READY=0 for 5 cycles in DONE.
  - SUM and OUT_VALID must stay stable.
  - IN_VALID=1 with new operands must be ignored.
  - OUT_READY=1 → IDLE next edge, then the new operands are accepted.
- Reset pulse at cnt=2 during A=0x1234+B=0x1111 → all outputs return to reset values. A following 0x1234+0x1111 yields SUM=0x2345.
- Build without RCA_SEQ_COUT_EN: C_OUT port is absent. Repeat the 0xFFFF+1 case → SUM=0x0000 with identical timing.
